// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI arbiter: FSM state encoding, grant
// encodings, default guard-cycle counts and the guard-timer load helper.
package spi_arb_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SETUP     = 3'd1,
        LOAD      = 3'd2,
        WAIT_BUSY = 3'd3,
        WAIT_DONE = 3'd4,
        HOLD      = 3'd5
    } arb_state_e;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_0    = 2'b01;
    localparam logic [1:0] GRANT_1    = 2'b10;

    localparam int DEF_CS_SETUP_CYCLES = 4;
    localparam int DEF_CS_HOLD_CYCLES  = 4;
    localparam int DEF_TIMEOUT_CYCLES  = 1023;

    localparam int TIMER_W = 16;

    // The timer is done when it reads 0, so an N-cycle interval loads N-1.
    function automatic logic [TIMER_W-1:0] guard_load(input int cycles);
        return (cycles > 0) ? TIMER_W'(cycles - 1) : '0;
    endfunction

endpackage

// File: rtl/spi_arb_guard_timer.sv
// Loadable down-counter with a done flag; shared by the CS setup interval,
// the CS hold interval and the spi_busy timeout.
module spi_arb_guard_timer
    import spi_arb_pkg::*;
#(
    parameter int W = TIMER_W
) (
    input  logic         raw_clk,
    input  logic         reset,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_value,
    output logic         done
);

    logic [W-1:0] count;

    // NOTE: sequential state is always written with <= so every flop samples
    // pre-edge values, independent of block evaluation order.
    always_ff @(posedge raw_clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (en && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin burst arbiter sharing one SPI master between the CPU register
// path (requester 0) and the ROM loader (requester 1). Define SPI_ARB_TIMEOUT_EN
// to enable the spi_busy timeout and the sticky error flag.
module spi_arbiter
    import spi_arb_pkg::*;
#(
    parameter int CS_SETUP_CYCLES = DEF_CS_SETUP_CYCLES,
    parameter int CS_HOLD_CYCLES  = DEF_CS_HOLD_CYCLES,
    parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
    input  logic       raw_clk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic       req1_valid,
    input  logic       req0_last,
    input  logic       req1_last,
    input  logic [7:0] req0_data,
    input  logic [7:0] req1_data,
    input  logic [2:0] req0_divisor,
    input  logic [2:0] req1_divisor,
    output logic       req0_ready,
    output logic       req1_ready,
    output logic       req0_rx_valid,
    output logic       req1_rx_valid,
    output logic [7:0] rx_data,
    output logic [1:0] grant,
    output logic       error,
    output logic       spi_start,
    output logic [7:0] spi_data_tx,
    output logic [2:0] spi_divisor,
    input  logic       spi_busy,
    input  logic [7:0] spi_data_rx,
    output logic       spi_cs
);

    arb_state_e         state;
    logic               owner;
    logic               ptr;
    logic               last_q;
    logic               pick;
    logic               own_valid;
    logic               own_last;
    logic [7:0]         own_data;
    logic               tmr_load;
    logic               tmr_en;
    logic [TIMER_W-1:0] tmr_value;
    logic               tmr_done;
    logic               timeout_hit;
    logic               burst_end;
    logic               release_now;

    assign own_valid = owner ? req1_valid : req0_valid;
    assign own_last  = owner ? req1_last  : req0_last;
    assign own_data  = owner ? req1_data  : req0_data;

    // NOTE: every always_comb output gets a default first so no path can
    // infer a latch.
    always_comb begin
        pick = req1_valid;
        if (req0_valid && req1_valid) begin
            pick = ptr;
        end
    end

    always_comb begin
        tmr_load  = 1'b0;
        tmr_en    = 1'b0;
        tmr_value = '0;
        unique case (state)
            IDLE: begin
                tmr_load  = 1'b1;
                tmr_value = guard_load(CS_SETUP_CYCLES);
            end
            SETUP: tmr_en = 1'b1;
            LOAD: begin
                tmr_load  = 1'b1;
                tmr_value = guard_load(TIMEOUT_CYCLES);
            end
            WAIT_BUSY: begin
                // On expiry the same counter is re-armed for the hold interval.
                if (tmr_done) begin
                    tmr_load  = 1'b1;
                    tmr_value = guard_load(CS_HOLD_CYCLES);
                end else begin
                    tmr_en = 1'b1;
                end
            end
            WAIT_DONE: begin
                tmr_load  = 1'b1;
                tmr_value = guard_load(CS_HOLD_CYCLES);
            end
            HOLD: tmr_en = 1'b1;
            default: ;
        endcase
    end

    spi_arb_guard_timer #(.W(TIMER_W)) u_guard_timer (
        .raw_clk    (raw_clk),
        .reset      (reset),
        .load       (tmr_load),
        .en         (tmr_en),
        .load_value (tmr_value),
        .done       (tmr_done)
    );

`ifdef SPI_ARB_TIMEOUT_EN
    logic error_q;
    assign timeout_hit = (state == WAIT_BUSY) && !spi_busy && tmr_done;
    assign error       = error_q;
`else
    assign timeout_hit = 1'b0;
    assign error       = 1'b0;
`endif

    // A zero hold time releases CS on the same edge that would enter HOLD.
    assign burst_end   = ((state == WAIT_DONE) && !spi_busy && last_q) || timeout_hit;
    assign release_now = ((state == HOLD) && tmr_done) ||
                         (burst_end && (CS_HOLD_CYCLES == 0));

    always_ff @(posedge raw_clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            owner         <= 1'b0;
            ptr           <= 1'b0;
            last_q        <= 1'b0;
            grant         <= GRANT_NONE;
            spi_cs        <= 1'b1;
            spi_start     <= 1'b0;
            spi_data_tx   <= '0;
            spi_divisor   <= '0;
            rx_data       <= '0;
            req0_ready    <= 1'b0;
            req1_ready    <= 1'b0;
            req0_rx_valid <= 1'b0;
            req1_rx_valid <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
            error_q       <= 1'b0;
`endif
        end else begin
            req0_ready    <= 1'b0;
            req1_ready    <= 1'b0;
            req0_rx_valid <= 1'b0;
            req1_rx_valid <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (req0_valid || req1_valid) begin
                        owner       <= pick;
                        grant       <= pick ? GRANT_1 : GRANT_0;
                        spi_cs      <= 1'b0;
                        spi_divisor <= pick ? req1_divisor : req0_divisor;
                        state       <= (CS_SETUP_CYCLES > 0) ? SETUP : LOAD;
                    end
                end
                SETUP: begin
                    if (tmr_done) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    // Owner keeps CS and the grant even while its valid is low.
                    if (own_valid) begin
                        spi_data_tx <= own_data;
                        req0_ready  <= ~owner;
                        req1_ready  <= owner;
                        last_q      <= own_last;
                        spi_start   <= 1'b1;
                        state       <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    if (spi_busy) begin
                        spi_start <= 1'b0;
                        state     <= WAIT_DONE;
                    end
`ifdef SPI_ARB_TIMEOUT_EN
                    else if (tmr_done) begin
                        spi_start <= 1'b0;
                        error_q   <= 1'b1;
                        state     <= HOLD;
                    end
`endif
                end
                WAIT_DONE: begin
                    if (!spi_busy) begin
                        rx_data       <= spi_data_rx;
                        req0_rx_valid <= ~owner;
                        req1_rx_valid <= owner;
                        state         <= last_q ? HOLD : LOAD;
                    end
                end
                HOLD: ;
                default: state <= IDLE;
            endcase

            if (release_now) begin
                spi_cs <= 1'b1;
                grant  <= GRANT_NONE;
                ptr    <= ~owner;
                state  <= IDLE;
            end
        end
    end

endmodule

// File: doc/spi_arbiter.md
Name: spi_arbiter

Overview:
- Shares the single SPI master between two requesters: requester 0 is the CPU peripheral-register path, requester 1 is the cartridge/ROM loader.
- Grants whole bursts round-robin and drives chip select with setup and hold guard times.
- Runs the start/busy handshake with the SPI master one byte at a time and returns each received byte to the owning requester.
- Sits between the peripheral register file / loader and the spi instance.

Parameters:
- CS_SETUP_CYCLES, 4, raw_clk cycles from CS low to the first spi_start.
- CS_HOLD_CYCLES, 4, raw_clk cycles from the last byte done to CS high.
- TIMEOUT_CYCLES, 1023, maximum cycles waiting for spi_busy to rise (optional feature only).

Ports:
- raw_clk  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset.
- req0_valid, req1_valid  in  1  byte pending; held until accepted.
- req0_last, req1_last  in  1  this byte ends the burst; qualified by valid.
- req0_data, req1_data  in  8  TX byte.
- req0_divisor, req1_divisor  in  3  SPI clock divisor for that requester.
- req0_ready, req1_ready  out  1  one-cycle pulse: byte accepted.
- req0_rx_valid, req1_rx_valid  out  1  one-cycle pulse: rx_data valid.
- rx_data  out  8  last received byte, shared by both requesters.
- grant  out  2  one-hot current owner; 0 when idle.
- error  out  1  sticky timeout flag (optional feature only).
- spi_start  out  1  to spi.start.
- spi_data_tx  out  8  to spi.data_tx.
- spi_divisor  out  3  to spi.divisor.
- spi_busy  in  1  from spi.busy.
- spi_data_rx  in  8  from spi.data_rx.
- spi_cs  out  1  active-low chip select.

Behaviour:
- Reset values: spi_cs=1, spi_start=0, grant=0, all ready/rx_valid=0, rx_data=0, spi_data_tx=0, spi_divisor=0, error=0, round-robin pointer=0, state IDLE.
- Asynchronous reset mid-transfer aborts immediately. CS rises with no hold time and no rx_valid pulse is issued.
- IDLE:
  - If one requester is valid, grant it.
  - If both are valid, grant the requester the pointer names. The pointer starts at 0, and that is the priority on a first-cycle tie.
  - grant, spi_cs=0 and spi_divisor latch on the next edge.
  - Go to SETUP with the counter at CS_SETUP_CYCLES.
- SETUP: count down. At 0, go to LOAD.
- LOAD:
  - If the owner's valid is high: latch data into spi_data_tx, pulse the owner's ready for 1 cycle, latch the last flag, set spi_start=1, go to WAIT_BUSY.
  - If valid is low: remain in LOAD with CS held low. Other requesters stay blocked; this is intended burst ownership.
- WAIT_BUSY: hold spi_start=1 until spi_busy=1 is sampled. Then clear spi_start and go to WAIT_DONE.
- WAIT_DONE:
  - On spi_busy=0, register spi_data_rx into rx_data and pulse the owner's rx_valid the following cycle.
  - If the latched last flag is 0, return to LOAD; if it is 1, go to HOLD.
- HOLD:
  - Count CS_HOLD_CYCLES.
  - Then set spi_cs=1 and grant=0, point the pointer at the other requester, and go to IDLE.
  - Minimum 1 idle cycle with CS high between bursts.
- Latency: ready pulse to spi_start high is 0 cycles (same edge). A single-byte burst costs 1 + SETUP + 1 + SPI time + 1 + HOLD + 1 cycles.
- The non-owner's ready and rx_valid never pulse. Its valid may stay high indefinitely.
- Owner valid with last=1 on the first byte is a single-byte burst.
- A CS_SETUP_CYCLES or CS_HOLD_CYCLES value of 0 skips that state.
- spi_divisor stays constant for the whole burst.

Optional Feature:
- Macro SPI_ARB_TIMEOUT_EN.
- Enabled:
  - WAIT_BUSY counts cycles. On reaching TIMEOUT_CYCLES it deasserts spi_start, sets error, and goes to HOLD with no rx_valid.
  - error is cleared only by reset.
- Disabled: no counter; WAIT_BUSY waits forever; the error port exists but is tied to 0.

Decomposition:
- Shared package spi_arb_pkg holds:
  - state encoding IDLE=0, SETUP=1, LOAD=2, WAIT_BUSY=3, WAIT_DONE=4, HOLD=5;
  - grant encodings GRANT_NONE=2'b00, GRANT_0=2'b01, GRANT_1=2'b10;
  - default guard-cycle constants.
- One sub-module, spi_arb_guard_timer: loadable down-counter with a done flag, reused for SETUP, HOLD and the timeout.

Test Plan:
- Req0 sends one byte 8'hA5 with last=1 against an SPI model that loops back → spi_data_tx=A5; ready0 pulses once; rx_valid0 pulses with rx_data=A5; CS low for at least SETUP+HOLD+transfer cycles; grant returns to 0.
- Both valid on the same cycle after reset → grant=01 first. Re-request both → grant=10 next (alternation verified over 4 bursts).
- Req1 three-byte burst 11,22,33, with req0 valid throughout → CS held low across all three bytes; grant stays 10; ready0/rx_valid0 never pulse.
- Owner drops valid mid-burst for 20 cycles → state stays LOAD with CS low; the burst completes normally when valid returns.
- Reset asserted during WAIT_DONE → same-cycle spi_cs=1, spi_start=0, grant=0; after release, pointer=0.
- With SPI_ARB_TIMEOUT_EN, spi_busy stuck at 0 → after 1023 cycles spi_start=0, error=1, CS rises after the hold time, no rx_valid.
